// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared bus constants and OAM DMA state encoding
package nes_bus_pkg;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_e;
  localparam logic [15:0] OAM_PORT_DEF = 16'h4014;
  localparam logic [15:0] OAM_DATA_DEF = 16'h2004;
  localparam int XFER_LEN = 256;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: CPU-halting page copy into the PPU OAM data port, with bus mux
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] OAM_PORT = OAM_PORT_DEF,
  parameter logic [15:0] OAM_DATA = OAM_DATA_DEF
) (
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_rdy,
  output logic        bus_master,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata,
  output logic        dma_active
);
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
  dma_state_e state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q, page_d, index_q, index_d, data_q, data_d;
  // state, parity and transfer registers; reset aborts any transfer in flight
  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      page_q   <= '0;
      index_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
    end
  end
  // next state and bus mux; the CPU owns the bus except in ALIGN/READ/WRITE
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    index_d    = index_q;
    data_d     = data_q;
    bus_master = 1'b0;
    bus_addr   = cpu_addr;
    bus_rw     = cpu_rw;
    bus_wdata  = cpu_wdata;
    case (state_q)
      IDLE: if (cpu_addr == OAM_PORT && !cpu_rw) begin
        page_d  = cpu_wdata;
        index_d = '0;
        state_d = HALT;
      end
      HALT: state_d = parity_q ? READ : ALIGN;
      ALIGN: begin
        bus_master = 1'b1;
        bus_addr   = {page_q, index_q};
        bus_rw     = 1'b1;
        state_d    = READ;
      end
      READ: begin
        bus_master = 1'b1;
        bus_addr   = {page_q, index_q};
        bus_rw     = 1'b1;
        data_d     = mem_rdata;
        state_d    = WRITE;
      end
      WRITE: begin
        bus_master = 1'b1;
        bus_addr   = OAM_DATA;
        bus_rw     = 1'b0;
        bus_wdata  = data_q;
        index_d    = index_q + 8'd1;
        state_d    = (index_q == LAST_IDX) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cpu_rdy    = (state_q == IDLE);
  assign dma_active = ~cpu_rdy;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed vectors and transfer sequences for oam_dma
module tb_oam_dma;
  logic        clk_ph2 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h4014;
  logic [7:0]  cpu_wdata = 8'h02;
  logic        cpu_rw = 1'b0;
  logic [7:0]  mem_rdata;
  logic        cpu_rdy, bus_master, bus_rw, dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  key_r = 8'h00;
  logic        tb_par;
  int n_chk = 0;
  int n_fail = 0;

  oam_dma dut (
    .clk_ph2(clk_ph2), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rw(cpu_rw), .mem_rdata(mem_rdata), .cpu_rdy(cpu_rdy),
    .bus_master(bus_master), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_wdata(bus_wdata), .dma_active(dma_active)
  );

  always #5 clk_ph2 = ~clk_ph2;

  // memory map model: low address byte scrambled by a per-test key
  always_comb mem_rdata = bus_addr[7:0] ^ key_r;

  // reference parity: 0 in the first cycle after reset, toggling every clock
  always @(posedge clk_ph2 or posedge rst)
    if (rst) tb_par <= 1'b0;
    else tb_par <= ~tb_par;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_idle();
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_rw = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_rw;
  } vec_t;

  task automatic run_xfer(input logic [7:0] page, input logic want_par, input int inject_at,
                          input int rst_at, input logic [7:0] key);
    logic        halt_par;
    logic [15:0] first_addr, prev_addr;
    int stall, reads, writes, errs, masters;
    bit did_rst;
    key_r = key;
    @(negedge clk_ph2);
    if (tb_par == want_par) @(negedge clk_ph2);
    cpu_addr = 16'h4014;
    cpu_wdata = page;
    cpu_rw = 1'b0;
    @(posedge clk_ph2);
    #1;
    cpu_idle();
    halt_par = tb_par;
    chk("halt_rdy", cpu_rdy, 0);
    chk("halt_master", bus_master, 0);
    chk("halt_active", dma_active, 1);
    stall = 1; reads = 0; writes = 0; errs = 0; did_rst = 0;
    first_addr = 16'hxxxx; prev_addr = 16'hxxxx;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk_ph2);
      #1;
      cpu_idle();
      if (cpu_rdy) break;
      stall++;
      if (!bus_master || !dma_active) errs++;
      else if (bus_rw) begin
        reads++;
        if (reads == 1) first_addr = bus_addr;
        if (bus_addr[15:8] != page) errs++;
      end else begin
        if (bus_addr !== 16'h2004 || prev_addr !== {page, 8'(writes)} ||
            bus_wdata !== (prev_addr[7:0] ^ key)) errs++;
        writes++;
        if (writes == inject_at) begin
          cpu_addr = 16'h4014;
          cpu_wdata = 8'h05;
          cpu_rw = 1'b0;
        end
        if (writes == rst_at) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_rdy", cpu_rdy, 1);
          chk("rst_master", bus_master, 0);
          chk("rst_active", dma_active, 0);
          chk("rst_passthru", bus_addr, 16'h0000);
          did_rst = 1;
          break;
        end
      end
      prev_addr = bus_addr;
    end
    if (did_rst) begin
      @(negedge clk_ph2);
      rst = 1'b0;
      masters = 0;
      for (int c = 0; c < 600; c++) begin
        @(posedge clk_ph2);
        #1;
        if (bus_master || !cpu_rdy || dma_active) masters++;
      end
      chk("post_rst_no_dma", masters, 0);
    end else begin
      chk("stall_cycles", stall, halt_par ? 513 : 514);
      chk("read_count", reads, halt_par ? 256 : 257);
      chk("write_count", writes, 256);
      chk("seq_errors", errs, 0);
      chk("first_addr", first_addr, {page, 8'h00});
      chk("done_rdy", cpu_rdy, 1);
      chk("done_active", dma_active, 0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1};
    vecs[1] = '{16'h4015, 8'h02, 1'b0, 16'h4015, 8'h02, 1'b0};
    vecs[2] = '{16'h2004, 8'h33, 1'b0, 16'h2004, 8'h33, 1'b0};
    vecs[3] = '{16'h4013, 8'h77, 1'b0, 16'h4013, 8'h77, 1'b0};
    vecs[4] = '{16'h0000, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1};
    vecs[5] = '{16'hC014, 8'h02, 1'b0, 16'hC014, 8'h02, 1'b0};
    #2;
    chk("reset_rdy", cpu_rdy, 1);
    chk("reset_master", bus_master, 0);
    chk("reset_active", dma_active, 0);
    chk("reset_passthru", {bus_addr, bus_wdata, bus_rw}, {16'h4014, 8'h02, 1'b0});
    #10;
    cpu_idle();
    #10;
    rst = 1'b0;
    repeat (3) @(posedge clk_ph2);
    #1;
    chk("after_reset_idle", dma_active, 0);
    foreach (vecs[i]) begin
      @(negedge clk_ph2);
      cpu_addr = vecs[i].addr;
      cpu_wdata = vecs[i].wdata;
      cpu_rw = vecs[i].rw;
      #1;
      chk($sformatf("v%0d_addr", i), bus_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_rw", i), bus_rw, vecs[i].exp_rw);
      chk($sformatf("v%0d_master", i), bus_master, 0);
      @(posedge clk_ph2);
      #1;
      chk($sformatf("v%0d_no_trigger", i), {dma_active, cpu_rdy}, 2'b01);
    end
    cpu_idle();
    run_xfer(8'h02, 1'b1, -1, -1, 8'hA5);
    run_xfer(8'h02, 1'b0, -1, -1, 8'hA5);
    run_xfer(8'h02, 1'b1, 100, -1, 8'h3C);
    run_xfer(8'h02, 1'b0, -1, 40, 8'hA5);
    run_xfer(8'hFF, 1'b1, -1, -1, 8'h00);
    run_xfer(8'hFF, 1'b0, -1, -1, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter OAM_PORT, default 16'h4014, CPU write address that triggers a transfer.
REQ-002 Parameter OAM_DATA, default 16'h2004, PPU OAM data port written by each transfer write.
REQ-003 clk_ph2  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr  input  16  CPU address bus.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 cpu_rw  input  1  CPU direction, 1=read, 0=write.
REQ-008 mem_rdata  input  8  data returned by the memory map for the current bus_addr.
REQ-009 cpu_rdy  output  1  0 = CPU stalled.
REQ-010 bus_master  output  1  1 = this block drives the system bus.
REQ-011 bus_addr  output  16  system address: cpu_addr when bus_master=0, DMA address otherwise.
REQ-012 bus_rw  output  1  system direction: cpu_rw when bus_master=0, DMA direction otherwise.
REQ-013 bus_wdata  output  8  system write data: cpu_wdata when bus_master=0, latched byte otherwise.
REQ-014 dma_active  output  1  1 from trigger until final write completes.

Function
REQ-015 States: IDLE, HALT, ALIGN, READ, WRITE; encoding shall be a package enum.
REQ-016 Free-running parity bit toggles every clock from reset value 0; a cycle with parity=0 is "even".
REQ-017 In IDLE, a clock with cpu_addr==OAM_PORT and cpu_rw==0 shall latch page<=cpu_wdata, index<=0, go to HALT.
REQ-018 HALT lasts exactly 1 cycle, cpu_rdy=0, bus_master=0; next state ALIGN if parity currently 0, else READ.
REQ-019 ALIGN lasts exactly 1 cycle, bus_master=1, bus_addr={page,index}, bus_rw=1, no data latched.
REQ-020 READ: bus_master=1, bus_addr={page,index}, bus_rw=1; latch mem_rdata into data register at clock end; next WRITE.
REQ-021 WRITE: bus_master=1, bus_addr=OAM_DATA, bus_rw=0, bus_wdata=data register; at clock end index<=index+1.
REQ-022 WRITE with index==8'hFF shall go to IDLE (index wraps to 0); otherwise go to READ.
REQ-023 Total stall (cpu_rdy=0) shall be 513 cycles when HALT is entered on odd parity, 514 on even parity.
REQ-024 cpu_rdy=0 and dma_active=1 in every non-IDLE state; cpu_rdy=1, dma_active=0, bus_master=0 in IDLE.
REQ-025 Writes to OAM_PORT while not IDLE shall be ignored; page and index unchanged.
REQ-026 Source address stays within page: {page,index} never carries into page; page 8'hFF reads 16'hFF00..16'hFFFF.
REQ-027 Reads of OAM_PORT (cpu_rw==1) shall never trigger.
REQ-028 Bus outputs are combinational from state, registers and CPU inputs; no other combinational input-to-output path.

Reset
REQ-029 rst asserted at any time, including mid-transfer, shall immediately force: state=IDLE, parity=0, page=0, index=0, data=0.
REQ-030 During and after reset: cpu_rdy=1, bus_master=0, dma_active=0, bus_* pass CPU inputs through.
REQ-031 No partial transfer resumes after reset release; a new OAM_PORT write is required.

Structure
REQ-032 Shared package nes_bus_pkg holds the state enum, OAM_PORT/OAM_DATA default constants and the transfer length constant 256.
REQ-033 Single module, no sub-modules; the address/data mux shall stay inside oam_dma.

Verification
REQ-034 Trigger: write 8'h02 to 16'h4014 on odd parity -> 513 cycles cpu_rdy=0; reads 16'h0200..16'h02FF in order; 256 writes to 16'h2004 with matching bytes.
REQ-035 Trigger on even parity -> exactly one ALIGN cycle, 514 stall cycles, first READ address 16'h0200.
REQ-036 Second write 8'h05 to 16'h4014 at write #100 -> ignored; all source addresses stay in page 8'h02.
REQ-037 rst pulse at write #40 -> same edge cpu_rdy=1, bus_master=0; no further 16'h2004 writes until a new trigger.
REQ-038 Page 8'hFF with memory model returning low address byte -> OAM receives 8'h00..8'hFF; no read outside 16'hFF00..16'hFFFF.
REQ-039 CPU read of 16'h4014, and CPU write to 16'h4015 -> no trigger; dma_active stays 0; bus pass-through unchanged.
